// File: rtl/hps_request_queue.sv
// Request FIFO feeding the HPS address PIO: the head request is held on out_addr and
// retired when the HPS flips ack_toggle, which is re-timed through a 2-flop synchronizer.
module hps_request_queue #(
  parameter int ADDR_W = 27,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_write,
  output logic              out_valid,
  input  logic              ack_toggle,
  output logic [PTR_W:0]    level,
  output logic              ack_err,
  input  logic              clr_err
);

  localparam int ENT_W = ADDR_W + 1;
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  logic [ENT_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [PTR_W:0]    level_r;
  logic [PTR_W:0]    level_nxt_s;
  logic              s1_r;
  logic              s2_r;
  logic              s3_r;
  logic              ack_evt_s;
  logic              push_s;
  logic              pop_s;
  logic              err_nxt_s;
  logic [ENT_W-1:0]  head_nxt_s;
  logic [ADDR_W-1:0] out_addr_r;
  logic              out_write_r;
  logic              out_valid_r;
  logic              ack_err_r;

  assign req_ready = (level_r != FULL_LVL);
  assign level     = level_r;
  assign out_addr  = out_addr_r;
  assign out_write = out_write_r;
  assign out_valid = out_valid_r;
  assign ack_err   = ack_err_r;

  // Next-state computation for pointers, occupancy, error flag and the head register
  always_comb begin
    ack_evt_s    = s2_r ^ s3_r;
    push_s       = req_valid && req_ready;
    pop_s        = ack_evt_s && (level_r != '0);
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    level_nxt_s  = level_r;
    err_nxt_s    = ack_err_r;
    head_nxt_s   = '0;

    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + 1'b1;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + 1'b1;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + 1'b1;
      2'b01:   level_nxt_s = level_r - 1'b1;
      default: level_nxt_s = level_r;
    endcase

    // A retire while empty sets the flag and takes priority over a clear
    if (ack_evt_s && (level_r == '0)) begin
      err_nxt_s = 1'b1;
    end else if (clr_err) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = ack_err_r;
    end

    // The new head may be the entry being written this cycle, which is not yet in mem_r
    if (level_nxt_s == '0) begin
      head_nxt_s = '0;
    end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = {req_write, req_addr};
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {req_write, req_addr};
    end
  end

  // Queue control state, ack synchronizer and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      s1_r        <= 1'b0;
      s2_r        <= 1'b0;
      s3_r        <= 1'b0;
      out_addr_r  <= '0;
      out_write_r <= 1'b0;
      out_valid_r <= 1'b0;
      ack_err_r   <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      level_r     <= level_nxt_s;
      s1_r        <= ack_toggle;
      s2_r        <= s1_r;
      s3_r        <= s2_r;
      out_addr_r  <= head_nxt_s[ADDR_W-1:0];
      out_write_r <= head_nxt_s[ADDR_W];
      out_valid_r <= (level_nxt_s != '0);
      ack_err_r   <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_hps_request_queue.sv
// Directed bench for hps_request_queue: ordering, full handling, push/pop overlap,
// pointer wrap, empty-ack error flag and asynchronous reset.
module tb_hps_request_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [26:0] req_addr;
  logic        req_write;
  logic [26:0] out_addr;
  logic        out_write;
  logic        out_valid;
  logic        ack_toggle;
  logic [2:0]  level;
  logic        ack_err;
  logic        clr_err;

  int checks = 0;
  int errors = 0;

  hps_request_queue #(.ADDR_W(27), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .out_addr(out_addr),
    .out_write(out_write), .out_valid(out_valid), .ack_toggle(ack_toggle),
    .level(level), .ack_err(ack_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [26:0] a, input logic w);
    req_valid = 1'b1; req_addr = a; req_write = w;
    tick();
    req_valid = 1'b0;
  endtask

  // flip the toggle and wait until the pop edge has passed
  task automatic ack_pulse();
    ack_toggle = ~ack_toggle;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
    checks++; if (out_addr !== 27'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", out_addr); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", ack_err); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
  endtask

  task automatic test_single(input string tag);
    push_one(27'h1234567, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %0b want 1", tag, out_valid); end
    checks++; if (out_addr !== 27'h1234567) begin errors++; $display("FAIL %s_addr: got %h want 1234567", tag, out_addr); end
    checks++; if (out_write !== 1'b0) begin errors++; $display("FAIL %s_write: got %0b want 0", tag, out_write); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL %s_level: got %0d want 1", tag, level); end
    ack_toggle = ~ack_toggle;
    tick(); tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_early_pop: got valid %0b want 1", tag, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_pop_valid: got %0b want 0", tag, out_valid); end
    checks++; if (out_addr !== 27'h0) begin errors++; $display("FAIL %s_pop_addr: got %h want 0", tag, out_addr); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL %s_pop_level: got %0d want 0", tag, level); end
  endtask

  task automatic test_order();
    push_one(27'h0000001, 1'b0);
    push_one(27'h7FFFFFF, 1'b1);
    push_one(27'h2AAAAAA, 1'b0);
    checks++; if (out_addr !== 27'h0000001) begin errors++; $display("FAIL ord_head_a: got %h want 0000001", out_addr); end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL ord_level3: got %0d want 3", level); end
    ack_pulse();
    checks++; if (out_addr !== 27'h7FFFFFF || out_write !== 1'b1) begin errors++; $display("FAIL ord_head_b: got %h/%0b want 7ffffff/1", out_addr, out_write); end
    repeat (5) tick();
    ack_pulse();
    checks++; if (out_addr !== 27'h2AAAAAA || out_write !== 1'b0) begin errors++; $display("FAIL ord_head_c: got %h/%0b want 2aaaaaa/0", out_addr, out_write); end
    repeat (5) tick();
    ack_pulse();
    checks++; if (out_valid !== 1'b0 || level !== 3'd0 || out_addr !== 27'h0) begin errors++; $display("FAIL ord_empty: got v%0b l%0d a%h want v0 l0 a0", out_valid, level, out_addr); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push_one(27'h100 + 27'(i), 1'b0);
    checks++; if (req_ready !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL full_state: got r%0b l%0d want r0 l4", req_ready, level); end
    req_valid = 1'b1; req_addr = 27'h0555555; req_write = 1'b0;
    tick();
    checks++; if (level !== 3'd4 || out_addr !== 27'h100) begin errors++; $display("FAIL full_hold: got l%0d a%h want l4 a100", level, out_addr); end
    ack_toggle = ~ack_toggle;
    tick(); tick();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_prepop: got l%0d want 4", level); end
    tick();
    checks++; if (level !== 3'd3 || req_ready !== 1'b1 || out_addr !== 27'h101) begin errors++; $display("FAIL full_pop: got l%0d r%0b a%h want l3 r1 a101", level, req_ready, out_addr); end
    tick();
    req_valid = 1'b0;
    checks++; if (level !== 3'd4 || req_ready !== 1'b0) begin errors++; $display("FAIL full_refill: got l%0d r%0b want l4 r0", level, req_ready); end
    ack_pulse();
    checks++; if (out_addr !== 27'h102) begin errors++; $display("FAIL full_drain1: got %h want 102", out_addr); end
    ack_pulse();
    checks++; if (out_addr !== 27'h103) begin errors++; $display("FAIL full_drain2: got %h want 103", out_addr); end
    ack_pulse();
    checks++; if (out_addr !== 27'h0555555 || level !== 3'd1) begin errors++; $display("FAIL full_drain_d: got %h l%0d want 0555555 l1", out_addr, level); end
    ack_pulse();
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL full_empty: got v%0b l%0d want v0 l0", out_valid, level); end
  endtask

  task automatic test_back_to_back();
    logic [27:0] exp_q[$];
    logic [26:0] exp_addr;
    push_one(27'h0ABCDEF, 1'b0);
    push_one(27'h1111111, 1'b1);
    ack_toggle = ~ack_toggle;
    tick(); tick();
    req_valid = 1'b1; req_addr = 27'h2222222; req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    checks++; if (level !== 3'd2 || out_addr !== 27'h1111111 || out_write !== 1'b1) begin errors++; $display("FAIL b2b_same_edge: got l%0d a%h w%0b want l2 a1111111 w1", level, out_addr, out_write); end
    exp_q.push_back({1'b1, 27'h1111111});
    exp_q.push_back({1'b0, 27'h2222222});
    for (int i = 0; i < 10; i++) begin
      push_one(27'h3000000 + 27'(i), i[0]);
      exp_q.push_back({i[0], 27'h3000000 + 27'(i)});
      ack_pulse();
      void'(exp_q.pop_front());
      checks++; if ({out_write, out_addr} !== exp_q[0] || level !== 3'(exp_q.size())) begin errors++; $display("FAIL b2b_wrap%0d: got %h l%0d want %h l%0d", i, {out_write, out_addr}, level, exp_q[0], exp_q.size()); end
    end
    repeat (2) begin
      ack_pulse();
      void'(exp_q.pop_front());
      exp_addr = (exp_q.size() > 0) ? exp_q[0][26:0] : 27'h0;
      checks++; if (out_addr !== exp_addr || level !== 3'(exp_q.size())) begin errors++; $display("FAIL b2b_drain: got %h l%0d want %h l%0d", out_addr, level, exp_addr, exp_q.size()); end
    end
  endtask

  task automatic test_ack_err();
    ack_toggle = ~ack_toggle;
    tick(); tick();
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL err_early: got %0b want 0", ack_err); end
    tick();
    checks++; if (ack_err !== 1'b1 || level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL err_set: got e%0b l%0d v%0b want e1 l0 v0", ack_err, level, out_valid); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %0b want 0", ack_err); end
    ack_toggle = ~ack_toggle;
    tick(); tick();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %0b want 1", ack_err); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL err_clr2: got %0b want 0", ack_err); end
  endtask

  task automatic test_async_reset();
    push_one(27'h0000AAA, 1'b0);
    push_one(27'h0000BBB, 1'b1);
    push_one(27'h0000CCC, 1'b0);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL ar_level3: got %0d want 3", level); end
    #2;
    reset_n = 1'b0;
    ack_toggle = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== 3'd0 || out_addr !== 27'h0) begin errors++; $display("FAIL ar_async: got v%0b l%0d a%h want v0 l0 a0", out_valid, level, out_addr); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    test_single("ar_after");
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_addr = 27'h0; req_write = 1'b0;
    ack_toggle = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    test_reset();
    test_single("single");
    test_order();
    test_full();
    test_back_to_back();
    test_ack_err();
    test_async_reset();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hps_request_queue.md
Name: hps_request_queue

Overview:
Upstream feeder for the HPS address PIO. Buffers memory requests (27-bit address plus write flag) issued by the LALU core and presents the oldest one on out_addr, which drives the PIO in_port that the HPS polls. The HPS retires the presented request by flipping a toggle bit through an output PIO. A 2-flop synchronizer on that toggle makes the block tolerant of an HPS-side clock.

Parameters:
ADDR_W, 27, request address width; must equal the PIO in_port width.
DEPTH, 4, FIFO entries; power of two, at least 2.
PTR_W, 2, log2(DEPTH).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  core has a request
req_ready  out  1  queue can accept a request this cycle
req_addr  in  ADDR_W  request address
req_write  in  1  1 = write request, 0 = read request
out_addr  out  ADDR_W  head address, to PIO in_port
out_write  out  1  head write flag
out_valid  out  1  queue non-empty
ack_toggle  in  1  HPS retire toggle, from output PIO
level  out  PTR_W+1  current occupancy, 0..DEPTH
ack_err  out  1  sticky: retire seen while empty
clr_err  in  1  synchronous clear of ack_err

Behaviour:
- Reset (async assert, sync release): FIFO flushed, pointers=0, level=0, out_valid=0, out_addr=0, out_write=0, ack_err=0, sync flops s1/s2/s3=0. HPS must drive ack_toggle=0 at reset.
- Reset mid-operation discards all queued entries. No partial state survives.
- req_ready = (level != DEPTH); depends only on registered state, not on req_valid or pop.
- Push occurs when req_valid && req_ready. Entry {req_write, req_addr} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Requester holds req_valid and its payload until accepted.
- req_valid while full: no push, no state change.
- Ack synchronizer: s1<=ack_toggle, s2<=s1, s3<=s2. ack_evt = s2 ^ s3.
- Latency: if ack_toggle changes before edge 0, ack_evt is high between edges 1 and 2. The pop commits at edge 2, and the new head is visible after edge 2.
- Each toggle retires exactly one entry. Toggles closer than 3 clk apart are not supported.
- Pop occurs when ack_evt && level != 0. rd_ptr increments modulo DEPTH.
- ack_evt && level == 0: no pop; ack_err<=1.
- clr_err clears ack_err. Simultaneous set and clear: set wins.
- Simultaneous push and pop: level unchanged, both pointers advance. This is legal at any level < DEPTH.
- When full, a pop frees the slot at the next edge; no same-cycle push-through.
- level updates at the edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Outputs registered:
  - out_valid = (level != 0) after the edge.
  - out_addr/out_write = entry at rd_ptr when non-empty, else 0.
  - Push into an empty queue: out_valid=1 and out_addr=pushed address on the cycle after the push edge.
- Head stability: out_addr/out_write hold constant until the pop edge, even while pushes continue.
- Pointer wrap: pointers wrap silently; full/empty are taken from level, not pointer equality.

Test Plan:
- Reset, then single push addr 0x1234567, wr=0 → next cycle out_valid=1, out_addr=0x1234567, out_write=0, level=1; toggle ack 0→1 → pop at 3rd edge: out_valid=0, out_addr=0, level=0.
- Push A=0x0000001, B=0x7FFFFFF (wr=1), C=0x2AAAAAA → out_addr=A; three acks 8 cycles apart → head sequence A, B(out_write=1), C, then empty; order preserved.
- Fill to 4 entries → req_ready=0, level=4; hold req_valid with D=0x0555555 → no push; ack → one cycle after pop, req_ready=1; D accepted next edge, level=4.
- Push and pop on the same edge at level=2 → level stays 2, head advances; run 10 entries through to exercise pointer wrap, with data in order.
- Ack toggle while empty → ack_err=1 at pop edge, level stays 0; clr_err pulse → ack_err=0; clr_err coincident with a new empty ack → ack_err=1.
- Assert reset_n=0 asynchronously with 3 entries queued mid-cycle → out_valid, level, out_addr=0 immediately; after release, a push behaves as first scenario.
